// File: rtl/rv32i_test_monitor.sv
// rv32i_test_monitor
//
// Self-check monitor for RV32I compliance programs in the riscv-tests style.
// It snoops the register-file writeback port and keeps shadow copies of the
// completion, pass-flag and test-number registers. Once the completion
// register is written with a nonzero value, it waits a settle window and then
// reports PASS or FAIL. A program that never completes is reported as
// TIMEOUT. Pass and fail totals accumulate across back-to-back programs until
// the next reset.
//
// Ports
//   sys_clk_i   in   1      single clock, rising edge
//   rst_n_i     in   1      asynchronous active-low reset
//   start_i     in   1      one-cycle pulse: begin monitoring a new program
//   wb_en_i     in   1      register-file write enable
//   wb_rd_i     in   5      destination register index
//   wb_data_i   in   XLEN   write data
//   busy_o      out  1      high in RUN or SETTLE
//   done_o      out  1      one-cycle pulse when a result is latched
//   pass_o      out  1      latched result: passed
//   fail_o      out  1      latched result: failed (includes timeout)
//   timeout_o   out  1      latched result: timed out
//   testnum_o   out  XLEN   latched test-number shadow
//   cycles_o    out  CNT_W  cycles spent in RUN+SETTLE for the current/last program
//   pass_cnt_o  out  16     programs passed since reset (saturating)
//   fail_cnt_o  out  16     programs failed since reset (saturating)
module rv32i_test_monitor #(
  parameter int XLEN           = 32,
  parameter int DONE_REG       = 26,
  parameter int PASS_REG       = 27,
  parameter int TESTNUM_REG    = 3,
  parameter int SETTLE_CYCLES  = 20,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 32
) (
  input  logic             sys_clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             wb_en_i,
  input  logic [4:0]       wb_rd_i,
  input  logic [XLEN-1:0]  wb_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [XLEN-1:0]  testnum_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic [15:0]      pass_cnt_o,
  output logic [15:0]      fail_cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;

  // The settle counter only ever holds SETTLE_CYCLES-1 down to 0.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [4:0]       DONE_IDX     = 5'(DONE_REG);
  localparam logic [4:0]       PASS_IDX     = 5'(PASS_REG);
  localparam logic [4:0]       TESTNUM_IDX  = 5'(TESTNUM_REG);
  localparam logic [SW-1:0]    SETTLE_LOAD  = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]    SETTLE_ONE   = SW'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [XLEN-1:0]  PASS_VALUE   = XLEN'(1);

  state_t          state;
  logic [SW-1:0]   settle_cnt;
  logic [XLEN-1:0] done_sh;
  logic [XLEN-1:0] pass_sh;
  logic [XLEN-1:0] testnum_sh;

  logic            hit_done;
  logic            hit_pass;
  logic            hit_testnum;
  logic            done_trig;
  logic            judge_now;
  logic            timeout_now;
  logic            finish_now;
  logic            pass_now;
  logic [XLEN-1:0] testnum_now;
  logic [CNT_W-1:0] cycles_next;

  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    hit_done    = wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == DONE_IDX);
    hit_pass    = wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == PASS_IDX);
    hit_testnum = wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == TESTNUM_IDX);

    // Only the first nonzero completion write of a program arms the settle
    // window. The done shadow is always zero while in RUN, so the guard just
    // restates "first completion only".
    done_trig   = (state == RUN) && hit_done && (wb_data_i != '0) && (done_sh == '0);
    judge_now   = (state == SETTLE) && (settle_cnt == '0);
    timeout_now = (state == RUN) && !done_trig && (cycles_o == TIMEOUT_LAST);
    finish_now  = judge_now || timeout_now;

    // The verdict sees a write landing on the judging edge itself.
    pass_now    = (hit_pass ? wb_data_i : pass_sh) == PASS_VALUE;
    testnum_now = hit_testnum ? wb_data_i : testnum_sh;

    cycles_next = (cycles_o == '1) ? cycles_o : cycles_o + CNT_ONE;
  end

  assign busy_o = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      settle_cnt <= '0;
      done_sh    <= '0;
      pass_sh    <= '0;
      testnum_sh <= '0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
      fail_o     <= 1'b0;
      timeout_o  <= 1'b0;
      testnum_o  <= '0;
      cycles_o   <= '0;
      pass_cnt_o <= '0;
      fail_cnt_o <= '0;
    end else begin
      done_o <= 1'b0;

      // Shadows track the writeback port in every state; start wins.
      if (start_i) begin
        done_sh    <= '0;
        pass_sh    <= '0;
        testnum_sh <= '0;
      end else begin
        if (hit_done)    done_sh    <= wb_data_i;
        if (hit_pass)    pass_sh    <= wb_data_i;
        if (hit_testnum) testnum_sh <= wb_data_i;
      end

      case (state)
        RUN: begin
          if (done_trig) begin
            state      <= SETTLE;
            settle_cnt <= SETTLE_LOAD;
            cycles_o   <= cycles_next;
          end else if (!timeout_now) begin
            cycles_o   <= cycles_next;
          end
        end
        SETTLE: begin
          if (!judge_now) begin
            settle_cnt <= settle_cnt - SETTLE_ONE;
            cycles_o   <= cycles_next;
          end
        end
        default: ;
      endcase

      if (finish_now) begin
        state     <= IDLE;
        done_o    <= 1'b1;
        testnum_o <= testnum_now;
        timeout_o <= timeout_now;
        pass_o    <= judge_now && pass_now;
        fail_o    <= !(judge_now && pass_now);
        if (judge_now && pass_now) begin
          if (pass_cnt_o != 16'hFFFF) pass_cnt_o <= pass_cnt_o + 16'd1;
        end else begin
          if (fail_cnt_o != 16'hFFFF) fail_cnt_o <= fail_cnt_o + 16'd1;
        end
      end

      // A start overrides the state transition. On a judging edge the fresh
      // verdict is kept visible for one more program; otherwise it is cleared.
      if (start_i) begin
        state    <= RUN;
        cycles_o <= '0;
        if (!finish_now) begin
          pass_o    <= 1'b0;
          fail_o    <= 1'b0;
          timeout_o <= 1'b0;
          testnum_o <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32i_test_monitor.sv
// Testbench for rv32i_test_monitor with a short settle window (4) and a short
// timeout (50). A directed vector table covers pass/fail/same-edge verdicts,
// hand sequences cover timeout, ignored writes, abort and reset, and a random
// phase is checked every cycle against a behavioural model.
module tb_rv32i_test_monitor;

  localparam int XLEN = 32;
  localparam int SC   = 4;
  localparam int TC   = 50;
  localparam int CW   = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            en = 1'b0;
  logic [4:0]      rd = 5'd0;
  logic [XLEN-1:0] data = '0;

  logic            busy, done, pass, fail, tmo;
  logic [XLEN-1:0] testnum;
  logic [CW-1:0]   cycles;
  logic [15:0]     pass_cnt, fail_cnt;

  always #5 clk = ~clk;

  rv32i_test_monitor #(
    .XLEN(XLEN), .DONE_REG(26), .PASS_REG(27), .TESTNUM_REG(3),
    .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC), .CNT_W(CW)
  ) dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .start_i(start), .wb_en_i(en),
    .wb_rd_i(rd), .wb_data_i(data), .busy_o(busy), .done_o(done),
    .pass_o(pass), .fail_o(fail), .timeout_o(tmo), .testnum_o(testnum),
    .cycles_o(cycles), .pass_cnt_o(pass_cnt), .fail_cnt_o(fail_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // A program is "running" from start until its verdict; after the first
  // nonzero completion write it has settle_left edges to go before judging.
  bit          m_running, m_settling;
  int          m_settle_left;
  int unsigned m_cycles;
  bit          m_done, m_pass, m_fail, m_to;
  logic [31:0] m_tn, sh_pass, sh_tn;
  int          m_pc, m_fc;

  task automatic model_reset();
    m_running = 0; m_settling = 0; m_settle_left = 0; m_cycles = 0;
    m_done = 0; m_pass = 0; m_fail = 0; m_to = 0; m_tn = 0;
    sh_pass = 0; sh_tn = 0; m_pc = 0; m_fc = 0;
  endtask

  task automatic model_edge();
    bit          wr, fin, ok, timed_out;
    logic [31:0] pass_v, tn_v;
    wr = en && (rd != 5'd0);
    pass_v = (wr && rd == 5'd27) ? data : sh_pass;
    tn_v   = (wr && rd == 5'd3)  ? data : sh_tn;
    fin = 0; ok = 0; timed_out = 0;
    m_done = 0;
    if (m_running && !m_settling) begin
      if (wr && rd == 5'd26 && data != 0) begin
        m_settling = 1;
        m_settle_left = SC;
        m_cycles++;
      end else if (m_cycles == TC - 1) begin
        fin = 1;
        timed_out = 1;
      end else begin
        m_cycles++;
      end
    end else if (m_running) begin
      m_settle_left--;
      if (m_settle_left == 0) begin
        fin = 1;
        ok = (pass_v == 1);
      end else begin
        m_cycles++;
      end
    end
    if (fin) begin
      m_running = 0; m_settling = 0; m_done = 1;
      m_pass = ok; m_fail = !ok; m_to = timed_out; m_tn = tn_v;
      if (ok) begin if (m_pc < 65535) m_pc++; end
      else    begin if (m_fc < 65535) m_fc++; end
    end
    if (wr && rd == 5'd27) sh_pass = data;
    if (wr && rd == 5'd3)  sh_tn = data;
    if (start) begin
      m_running = 1; m_settling = 0; m_cycles = 0;
      sh_pass = 0; sh_tn = 0;
      if (!fin) begin m_pass = 0; m_fail = 0; m_to = 0; m_tn = 0; end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".busy"},     32'(busy),     32'(m_running));
    check({tag, ".done"},     32'(done),     32'(m_done));
    check({tag, ".pass"},     32'(pass),     32'(m_pass));
    check({tag, ".fail"},     32'(fail),     32'(m_fail));
    check({tag, ".timeout"},  32'(tmo),      32'(m_to));
    check({tag, ".testnum"},  testnum,       m_tn);
    check({tag, ".cycles"},   cycles,        m_cycles);
    check({tag, ".pass_cnt"}, 32'(pass_cnt), 32'(m_pc));
    check({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(m_fc));
  endtask

  // Inputs are changed 1 ns after the rising edge and sampled there by both
  // DUT and model; outputs are compared at that same point.
  task automatic drive(input logic s, input logic e, input logic [4:0] r, input logic [31:0] d);
    start = s; en = e; rd = r; data = d;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_model(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'd0);
      tick(tag);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        start, en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        busy, done, pass, fail;
    logic [31:0] tn;
    int          pc, fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic e, input logic [4:0] r, input logic [31:0] d,
                              input logic b, input logic dn, input logic p, input logic f,
                              input logic [31:0] t, input int pc, input int fc);
    vec_t v;
    v.start = s; v.en = e; v.rd = r; v.data = d;
    v.busy = b; v.done = dn; v.pass = p; v.fail = f; v.tn = t; v.pc = pc; v.fc = fc;
    return v;
  endfunction

  task automatic build_table();
    // Program 1: x3=5, x27=1, x26=1 -> pass, testnum 5.
    vecs.push_back(mk(1, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 9; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3,  5, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 27, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 26, 1, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < SC - 1; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 1, 0, 5, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 1, 0, 5, 1, 0));
    // Program 2: x3=7, x27=0 -> fail, testnum 7.
    vecs.push_back(mk(1, 0, 0,  0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3,  7, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 27, 0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 26, 1, 1, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < SC - 1; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 7, 1, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1, 7, 1, 1));
    // Program 3: as program 2, but x27=1 lands on the judging edge -> pass.
    vecs.push_back(mk(1, 0, 0,  0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 3,  7, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 27, 0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 26, 1, 1, 0, 0, 0, 0, 1, 1));
    for (int i = 0; i < SC - 1; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 27, 1, 0, 1, 1, 0, 7, 2, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 0, 1, 0, 7, 2, 1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    #2;
    compare_model("reset");
    rst_n = 1'b1;

    build_table();
    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].en, vecs[i].rd, vecs[i].data);
      tick("table_model");
      check($sformatf("vec%0d.busy", i),     32'(busy),     32'(vecs[i].busy));
      check($sformatf("vec%0d.done", i),     32'(done),     32'(vecs[i].done));
      check($sformatf("vec%0d.pass", i),     32'(pass),     32'(vecs[i].pass));
      check($sformatf("vec%0d.fail", i),     32'(fail),     32'(vecs[i].fail));
      check($sformatf("vec%0d.testnum", i),  testnum,       vecs[i].tn);
      check($sformatf("vec%0d.pass_cnt", i), 32'(pass_cnt), 32'(vecs[i].pc));
      check($sformatf("vec%0d.fail_cnt", i), 32'(fail_cnt), 32'(vecs[i].fc));
    end

    // Timeout: no completion write for TC RUN edges.
    drive(1'b1, 1'b0, 5'd0, 32'd0);
    tick("to_start");
    check("to.cycles_after_start", cycles, 32'd0);
    idle(TC - 1, "to_run");
    check("to.no_done_yet", 32'(done), 32'd0);
    idle(1, "to_edge");
    check("to.done",    32'(done), 32'd1);
    check("to.timeout", 32'(tmo),  32'd1);
    check("to.fail",    32'(fail), 32'd1);
    check("to.pass",    32'(pass), 32'd0);
    check("to.cycles",  cycles,    32'(TC - 1));
    check("to.fail_cnt", 32'(fail_cnt), 32'd2);

    // Ignored writes (rd=0, x26=0) and a second x26 write during SETTLE.
    drive(1'b1, 1'b0, 5'd0, 32'd0);
    tick("ign_start");
    drive(1'b0, 1'b1, 5'd0, 32'd1);
    tick("ign_rd0");
    drive(1'b0, 1'b1, 5'd26, 32'd0);
    tick("ign_zero");
    idle(2, "ign_wait");
    check("ign.still_busy", 32'(busy), 32'd1);
    drive(1'b0, 1'b1, 5'd26, 32'd5);
    tick("ign_trig");
    drive(1'b0, 1'b1, 5'd26, 32'd9);
    tick("ign_retrig");
    check("ign.no_done_d1", 32'(done), 32'd0);
    idle(SC - 2, "ign_settle");
    check("ign.no_done_d3", 32'(done), 32'd0);
    check("ign.busy_d3",    32'(busy), 32'd1);
    idle(1, "ign_judge");
    check("ign.done_d4", 32'(done), 32'd1);
    check("ign.fail",    32'(fail), 32'd1);
    check("ign.fail_cnt", 32'(fail_cnt), 32'd3);

    // Abort mid-RUN, then start again on the judging edge.
    drive(1'b1, 1'b0, 5'd0, 32'd0);
    tick("ab_start1");
    idle(5, "ab_run1");
    drive(1'b1, 1'b0, 5'd0, 32'd0);
    tick("ab_start2");
    check("ab.cycles_restart", cycles, 32'd0);
    idle(3, "ab_run2");
    drive(1'b0, 1'b1, 5'd27, 32'd1);
    tick("ab_pass_w");
    drive(1'b0, 1'b1, 5'd26, 32'd1);
    tick("ab_done_w");
    idle(SC - 1, "ab_settle");
    drive(1'b1, 1'b0, 5'd0, 32'd0);
    tick("ab_judge_start");
    check("ab.done",     32'(done),     32'd1);
    check("ab.pass",     32'(pass),     32'd1);
    check("ab.busy",     32'(busy),     32'd1);
    check("ab.cycles",   cycles,        32'd0);
    check("ab.pass_cnt", 32'(pass_cnt), 32'd3);
    check("ab.fail_cnt", 32'(fail_cnt), 32'd3);
    idle(1, "ab_next");
    check("ab.done_once",   32'(done), 32'd0);
    check("ab.pass_held",   32'(pass), 32'd1);
    check("ab.cycles_next", cycles,    32'd1);
    drive(1'b1, 1'b0, 5'd0, 32'd0);
    tick("ab_clear");
    check("ab.pass_cleared", 32'(pass), 32'd0);

    // Reset during SETTLE.
    drive(1'b0, 1'b1, 5'd26, 32'd1);
    tick("rs_trig");
    idle(2, "rs_settle");
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rs.busy",     32'(busy),     32'd0);
    check("rs.done",     32'(done),     32'd0);
    check("rs.pass",     32'(pass),     32'd0);
    check("rs.fail",     32'(fail),     32'd0);
    check("rs.timeout",  32'(tmo),      32'd0);
    check("rs.testnum",  testnum,       32'd0);
    check("rs.cycles",   cycles,        32'd0);
    check("rs.pass_cnt", 32'(pass_cnt), 32'd0);
    check("rs.fail_cnt", 32'(fail_cnt), 32'd0);
    rst_n = 1'b1;
    idle(SC + 2, "rs_after");

    // Random traffic: dense writes, then sparse writes so timeouts occur.
    for (int i = 0; i < 2400; i++) begin
      logic [4:0]  r;
      logic [31:0] d;
      int          en_pct;
      en_pct = (i < 1200) ? 50 : 4;
      case ($urandom_range(0, 4))
        0:       r = 5'd0;
        1:       r = 5'd3;
        2:       r = 5'd26;
        3:       r = 5'd27;
        default: r = 5'($urandom_range(0, 31));
      endcase
      case ($urandom_range(0, 3))
        0:       d = 32'd0;
        1:       d = 32'd1;
        2:       d = 32'($urandom_range(2, 9));
        default: d = $urandom;
      endcase
      drive(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < en_pct) ? 1'b1 : 1'b0, r, d);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
